// File: rtl/payload_match_reporter.sv
// Snapshots engine match bits at end of payload and serialises each set bit
// as an (engine id, packet sequence) report over a valid/ready interface.
module payload_match_reporter #(
    parameter int NUM_ENGINES = 64,
    parameter int ID_W        = 6,
    parameter int SEQ_W       = 16,
    parameter int DROP_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   sod,
    input  logic                   eod,
    input  logic [NUM_ENGINES-1:0] match_in,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [ID_W-1:0]        rpt_engine_id,
    output logic [SEQ_W-1:0]       rpt_seq,
    output logic                   rpt_last,
    output logic                   busy,
    output logic                   gap_err,
    output logic [DROP_W-1:0]      drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_ENGINES-1:0] snap_q, snap_d;
    logic [SEQ_W-1:0]       seq_cnt_q, seq_cnt_d;
    logic [SEQ_W-1:0]       cur_seq_q, cur_seq_d;
    logic [DROP_W-1:0]      drop_q, drop_d;
    logic                   gap_q, gap_d;

    logic                   eod_ev;
    logic [NUM_ENGINES-1:0] snap_rest;
    logic [ID_W-1:0]        low_id;

    assign eod_ev    = en & eod;
    // snapshot with its lowest set bit removed
    assign snap_rest = snap_q & (snap_q - NUM_ENGINES'(1));

    always_comb begin
        low_id = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (snap_q[i]) low_id = ID_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        seq_cnt_d = seq_cnt_q;
        cur_seq_d = cur_seq_q;
        drop_d    = drop_q;
        gap_d     = gap_q;

        // every packet consumes a sequence number, accepted or dropped
        if (eod_ev) seq_cnt_d = seq_cnt_q + SEQ_W'(1);

        unique case (state_q)
            IDLE: begin
                if (eod_ev) begin
                    cur_seq_d = seq_cnt_q;
                    state_d   = SNAP;
                end
            end
            SNAP: begin
                snap_d  = match_in;
                state_d = (match_in == '0) ? IDLE : EMIT;
                if (sod) gap_d = 1'b1;
            end
            EMIT: begin
                if (rpt_ready) begin
                    snap_d = snap_rest;
                    if (snap_rest == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (eod_ev && state_q != IDLE && drop_q != '1)
            drop_d = drop_q + DROP_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            seq_cnt_q <= '0;
            cur_seq_q <= '0;
            drop_q    <= '0;
            gap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            seq_cnt_q <= seq_cnt_d;
            cur_seq_q <= cur_seq_d;
            drop_q    <= drop_d;
            gap_q     <= gap_d;
        end
    end

    assign rpt_valid     = (state_q == EMIT);
    assign rpt_engine_id = low_id;
    assign rpt_seq       = cur_seq_q;
    assign rpt_last      = rpt_valid && (snap_rest == '0);
    assign busy          = (state_q != IDLE);
    assign gap_err       = gap_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_payload_match_reporter.sv
// Bench for payload_match_reporter: directed and random packets against a
// queue-based expected-report model, plus a narrow instance for wrap/saturation.
module tb_payload_match_reporter;

    localparam int N = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         en, sod, eod, rpt_ready;
    logic [N-1:0] match_in;
    logic         rpt_valid, rpt_last, busy, gap_err;
    logic [5:0]   rpt_engine_id;
    logic [15:0]  rpt_seq, drop_cnt;

    logic         s_en, s_sod, s_eod, s_ready;
    logic [7:0]   s_match;
    logic         s_valid, s_last, s_busy, s_gap;
    logic [2:0]   s_id;
    logic [3:0]   s_seq;
    logic [1:0]   s_drop;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_seq  = 0;

    payload_match_reporter #(
        .NUM_ENGINES(N), .ID_W(6), .SEQ_W(16), .DROP_W(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sod(sod), .eod(eod),
        .match_in(match_in), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_engine_id(rpt_engine_id), .rpt_seq(rpt_seq),
        .rpt_last(rpt_last), .busy(busy), .gap_err(gap_err),
        .drop_cnt(drop_cnt)
    );

    payload_match_reporter #(
        .NUM_ENGINES(8), .ID_W(3), .SEQ_W(4), .DROP_W(2)
    ) dut_s (
        .clk(clk), .rst(rst), .en(s_en), .sod(s_sod), .eod(s_eod),
        .match_in(s_match), .rpt_valid(s_valid), .rpt_ready(s_ready),
        .rpt_engine_id(s_id), .rpt_seq(s_seq),
        .rpt_last(s_last), .busy(s_busy), .gap_err(s_gap),
        .drop_cnt(s_drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void build(input logic [N-1:0] v, output int ids[$]);
        ids = {};
        for (int i = 0; i < N; i++) if (v[i]) ids.push_back(i);
    endfunction

    // Called at a negedge where the DUT is expected to be in EMIT.
    task automatic drain(input int ids_in[$], input int cur, input bit rnd,
                         input logic [31:0] pat);
        int ids[$];
        int j;
        ids = ids_in;
        j = 0;
        while (ids.size() > 0 && j < 300) begin
            chk("valid", {63'd0, rpt_valid}, 64'd1);
            chk("id", {58'd0, rpt_engine_id}, 64'(ids[0]));
            chk("seq", {48'd0, rpt_seq}, 64'(cur));
            chk("last", {63'd0, rpt_last}, {63'd0, ids.size() == 1});
            rpt_ready = rnd ? 1'($urandom_range(0, 1)) : (j < 32 ? pat[j] : 1'b1);
            if (rpt_ready) void'(ids.pop_front());
            j++;
            @(negedge clk);
        end
        chk("drain_left", 64'(ids.size()), 64'd0);
        chk("done_valid", {63'd0, rpt_valid}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd0);
        rpt_ready = 1'b0;
    endtask

    task automatic run_pkt(input logic [N-1:0] v, input bit rnd,
                           input logic [31:0] pat);
        int ids[$];
        int cur;
        build(v, ids);
        @(negedge clk);
        en = 1'b1; eod = 1'b1; match_in = v;
        @(negedge clk);
        en = 1'b0; eod = 1'b0;
        chk("snap_busy", {63'd0, busy}, 64'd1);
        chk("snap_valid", {63'd0, rpt_valid}, 64'd0);
        cur = exp_seq;
        exp_seq = (exp_seq + 1) % 65536;
        @(negedge clk);
        if (ids.size() == 0) begin
            chk("empty_valid", {63'd0, rpt_valid}, 64'd0);
            chk("empty_busy", {63'd0, busy}, 64'd0);
        end else begin
            drain(ids, cur, rnd, pat);
        end
    endtask

    initial begin : main
        int ids[$];
        int cur;
        logic [N-1:0] v;

        rst = 1'b1;
        en = 0; sod = 0; eod = 0; rpt_ready = 0; match_in = '0;
        s_en = 0; s_sod = 0; s_eod = 0; s_ready = 0; s_match = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, rpt_valid}, 64'd0);
        chk("rst_id", {58'd0, rpt_engine_id}, 64'd0);
        chk("rst_seq", {48'd0, rpt_seq}, 64'd0);
        chk("rst_last", {63'd0, rpt_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_gap", {63'd0, gap_err}, 64'd0);
        chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_pkt('0, 1'b0, 32'hFFFF_FFFF);
        v = '0; v[3] = 1'b1; v[17] = 1'b1; v[63] = 1'b1;
        run_pkt(v, 1'b0, 32'hFFFF_FFFF);
        run_pkt(v, 1'b0, 32'hFFFF_FFE9);

        // drop while stalled in EMIT; sod in EMIT must not disturb anything
        v = 64'hFF;
        build(v, ids);
        @(negedge clk);
        en = 1'b1; eod = 1'b1; match_in = v;
        @(negedge clk);
        en = 1'b0; eod = 1'b0;
        cur = exp_seq;
        exp_seq = exp_seq + 1;
        repeat (3) @(negedge clk);
        en = 1'b1; eod = 1'b1;
        @(negedge clk);
        en = 1'b0; eod = 1'b0; sod = 1'b1;
        exp_seq = exp_seq + 1;
        chk("drop_one", {48'd0, drop_cnt}, 64'd1);
        @(negedge clk);
        sod = 1'b0;
        repeat (5) @(negedge clk);
        chk("emit_sod_gap", {63'd0, gap_err}, 64'd0);
        drain(ids, cur, 1'b0, 32'hFFFF_FFFF);
        v = '0; v[40] = 1'b1;
        run_pkt(v, 1'b0, 32'hFFFF_FFFF);

        // eod on the edge EMIT returns to IDLE is a drop
        @(negedge clk);
        en = 1'b1; eod = 1'b1; match_in = 64'h4;
        @(negedge clk);
        en = 1'b0; eod = 1'b0;
        exp_seq = exp_seq + 1;
        @(negedge clk);
        chk("edge_valid", {63'd0, rpt_valid}, 64'd1);
        rpt_ready = 1'b1; en = 1'b1; eod = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0; en = 1'b0; eod = 1'b0;
        exp_seq = exp_seq + 1;
        chk("edge_valid_off", {63'd0, rpt_valid}, 64'd0);
        chk("edge_busy", {63'd0, busy}, 64'd0);
        chk("edge_drop", {48'd0, drop_cnt}, 64'd2);

        for (int k = 0; k < 12; k++) begin
            v = {$urandom, $urandom} & {$urandom, $urandom};
            run_pkt(v, 1'b1, 32'h0);
        end

        // sod in the SNAP cycle
        @(negedge clk);
        en = 1'b1; eod = 1'b1; match_in = '0;
        @(negedge clk);
        en = 1'b0; eod = 1'b0; sod = 1'b1;
        exp_seq = exp_seq + 1;
        @(negedge clk);
        sod = 1'b0;
        chk("gap_set", {63'd0, gap_err}, 64'd1);
        run_pkt('0, 1'b0, 32'hFFFF_FFFF);
        chk("gap_sticky", {63'd0, gap_err}, 64'd1);

        // asynchronous reset in the middle of EMIT
        @(negedge clk);
        en = 1'b1; eod = 1'b1; match_in = 64'h3;
        @(negedge clk);
        en = 1'b0; eod = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {63'd0, rpt_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, rpt_valid}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_drop", {48'd0, drop_cnt}, 64'd0);
        chk("arst_gap", {63'd0, gap_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_seq = 0;
        v = '0; v[5] = 1'b1;
        run_pkt(v, 1'b0, 32'hFFFF_FFFF);

        // narrow instance: sequence wrap and drop saturation
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            s_en = 1'b1; s_eod = 1'b1; s_match = '0;
            @(negedge clk);
            s_en = 1'b0; s_eod = 1'b0;
        end
        @(negedge clk);
        s_en = 1'b1; s_eod = 1'b1; s_match = 8'h20;
        @(negedge clk);
        s_en = 1'b0; s_eod = 1'b0;
        @(negedge clk);
        chk("s_top_valid", {63'd0, s_valid}, 64'd1);
        chk("s_top_id", {61'd0, s_id}, 64'd5);
        chk("s_top_seq", {60'd0, s_seq}, 64'hF);
        chk("s_top_last", {63'd0, s_last}, 64'd1);
        s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;
        chk("s_top_done", {63'd0, s_valid}, 64'd0);

        s_en = 1'b1; s_eod = 1'b1; s_match = 8'h80;
        @(negedge clk);
        s_en = 1'b0; s_eod = 1'b0;
        @(negedge clk);
        chk("s_wrap_id", {61'd0, s_id}, 64'd7);
        chk("s_wrap_seq", {60'd0, s_seq}, 64'd0);
        s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;

        s_en = 1'b1; s_eod = 1'b1; s_match = 8'h01;
        @(negedge clk);
        s_en = 1'b0; s_eod = 1'b0;
        @(negedge clk);
        s_en = 1'b1; s_eod = 1'b1;
        repeat (4) @(negedge clk);
        s_en = 1'b0; s_eod = 1'b0;
        chk("s_drop_sat", {62'd0, s_drop}, 64'd3);
        chk("s_hold_id", {61'd0, s_id}, 64'd0);
        chk("s_hold_seq", {60'd0, s_seq}, 64'd1);
        s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;
        chk("s_sat_done", {63'd0, s_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/payload_match_reporter.md
Name: payload_match_reporter

Overview:
- Downstream consumer of the per-rule payload engines.
- Snapshots the sticky match outputs of up to NUM_ENGINES engines at end of each packet payload.
- Serialises every set bit as an (engine id, packet sequence) report over a valid/ready interface to the alert/logging stage.
- Tracks per-packet sequence numbers and counts packets whose matches were dropped because the reporter was busy.

Parameters:
NUM_ENGINES, 64, number of engine match inputs (1..256)
ID_W, 6, width of engine index; must satisfy 2**ID_W >= NUM_ENGINES
SEQ_W, 16, width of packet sequence counter
DROP_W, 16, width of dropped-packet counter

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous active-high reset
en  input  1  payload byte strobe, same signal that drives the engines' enable
sod  input  1  start of data; same pulse that clears the engines
eod  input  1  end of data; qualifies the last payload byte, valid only with en=1
match_in  input  NUM_ENGINES  engine "out" bits, bit i = engine i
rpt_valid  output  1  report available
rpt_ready  input  1  downstream accepts report
rpt_engine_id  output  ID_W  index of matching engine
rpt_seq  output  SEQ_W  sequence number of packet that matched
rpt_last  output  1  this report is the final one for the packet
busy  output  1  high in SNAP or EMIT
gap_err  output  1  sticky: sod seen in SNAP cycle
drop_cnt  output  DROP_W  packets lost while busy, saturating

Behaviour:
- Reset (async): state IDLE, snap_reg=0, seq_cnt=0, drop_cnt=0, gap_err=0.
- Reset (async), outputs: rpt_valid=0, rpt_engine_id=0, rpt_seq=0, rpt_last=0, busy=0.
- Engines register on en, so the last byte's match is visible one cycle after the eod byte. An eod event is en&eod at edge k.
- State IDLE:
  - On eod event: latch cur_seq<=seq_cnt, seq_cnt<=seq_cnt+1 (wraps modulo 2**SEQ_W), go to SNAP.
- State SNAP (exactly one cycle):
  - At edge k+1: snap_reg<=match_in.
  - If match_in==0, go to IDLE and emit no report.
  - Otherwise go to EMIT.
  - If sod=1 during SNAP, set gap_err (sticky until rst). The snapshot is still taken; its contents are undefined because sod clears the engines asynchronously.
  - Upstream guarantees at least one cycle between eod and the next sod.
- State EMIT:
  - rpt_valid=1.
  - rpt_engine_id = index of lowest set bit of snap_reg.
  - rpt_seq = cur_seq.
  - rpt_last=1 iff exactly one bit is set in snap_reg.
  - All report outputs are derived from registers only and are stable while rpt_valid=1 and rpt_ready=0.
  - On rpt_valid&rpt_ready: clear that bit of snap_reg. If it was the last bit, go to IDLE (rpt_valid=0 next cycle); otherwise stay in EMIT with the next lowest bit.
  - Throughput is one report per cycle with rpt_ready held high.
  - First rpt_valid is high in the cycle after edge k+1.
- Busy overlap:
  - An eod event while state is SNAP or EMIT drops that packet: no snapshot; drop_cnt+1, saturating at all-ones.
  - seq_cnt still increments, so downstream can detect the gap.
  - An eod event on the same edge that EMIT returns to IDLE counts as a drop.
  - An eod event in IDLE is accepted.
- sod has no effect on the reporter state except the gap_err check. A sod in EMIT does not disturb snap_reg.
- rst mid-EMIT: all pending reports are discarded and rpt_valid drops immediately (async).
- Match bits at indices >= NUM_ENGINES do not exist. With NUM_ENGINES < 2**ID_W, rpt_engine_id never exceeds NUM_ENGINES-1.

Test Plan:
- Single packet, match_in=0x0000_0000_0000_0000 at snapshot -> no rpt_valid, seq_cnt 0->1, busy high exactly 1 cycle.
- Packet, match_in bits 3,17,63 set, rpt_ready=1 -> three consecutive cycles: ids 3,17,63, rpt_seq=0, rpt_last only on id 63; first valid in the cycle after the snapshot edge.
- Same vector with rpt_ready toggling 1,0,0,1,0,1 -> ids/seq/last stay stable while stalled; each id is reported exactly once, in ascending order.
- Second eod event during EMIT of packet 0 (bits 0..7 set, rpt_ready=0 for 10 cycles) -> drop_cnt=1; next accepted packet reports rpt_seq=2; packet 0 still delivers ids 0..7.
- sod asserted in the SNAP cycle -> gap_err=1 and stays 1 until rst; rst asserted mid-EMIT -> rpt_valid=0, busy=0, drop_cnt=0, gap_err=0 without waiting for a clock.
- Set seq_cnt to 0xFFFF via 65535 empty packets, then a packet with bit 5 set -> report id 5 with rpt_seq=0xFFFF; following packet uses rpt_seq=0x0000; drop_cnt saturation checked with DROP_W=2 (4 drops -> 3).
